// File: rtl/button_conditioner_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Defaults assume a 24 MHz pll_clk: 10 ms debounce, 1 s long press, 200 ms repeat.
package button_conditioner_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        LONG,
        DEB_REL
    } btn_state_t;

    localparam int CLK_HZ       = 24_000_000;
    localparam int DEF_DEBOUNCE = CLK_HZ / 100;
    localparam int DEF_LONG     = CLK_HZ;
    localparam int DEF_REPEAT   = CLK_HZ / 5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Pad-side inputs and conditioned event outputs of the button conditioner.
// slave is the conditioner; master is whoever drives pads and consumes events.
interface button_conditioner_if #(
    parameter int NUM_BTN = 2
);

    logic [NUM_BTN-1:0] btn_in;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_long;
    logic [NUM_BTN-1:0] btn_repeat;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long,
        input  btn_repeat
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long,
        output btn_repeat
    );

endinterface

// File: rtl/button_conditioner_channel.sv
// One button: 2-FF synchroniser, debounce FSM and a single shared counter
// reused for debounce, hold and repeat timing.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter logic ACTIVE          = 1'b1,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter int   LONG_CYCLES     = 20,
    parameter int   REPEAT_CYCLES   = 8,
    parameter int   CW              = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic press,
    output logic rel,
    output logic lng,
    output logic rpt
);

    localparam logic [CW-1:0] DEB_END = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LNG_END = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] RPT_END = CW'(REPEAT_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          pol;
    btn_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_d, rel_d, lng_d, rpt_d;

    // Reset loads the idle level so a held button reads as a fresh press.
    always_ff @(posedge clk) begin
        if (!reset_n) sync_q <= {2{~ACTIVE}};
        else          sync_q <= {sync_q[0], pin};
    end

    assign pol = ~(sync_q[1] ^ ACTIVE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        press_d = 1'b0;
        rel_d   = 1'b0;
        lng_d   = 1'b0;
        rpt_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pol) state_d = DEB_PRESS;
            end
            DEB_PRESS: begin
                if (!pol) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_END) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (!pol) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end else if (cnt_q == LNG_END) begin
                    state_d = LONG;
                    cnt_d   = '0;
                    lng_d   = 1'b1;
                end
            end
            LONG: begin
                if (!pol) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end else if (cnt_q == RPT_END) begin
                    cnt_d = '0;
                    rpt_d = 1'b1;
                end
            end
            DEB_REL: begin
                if (pol) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_END) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
            rel     <= 1'b0;
            lng     <= 1'b0;
            rpt     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= (state_q == PRESSED) || (state_q == LONG) ||
                       (state_q == DEB_REL);
            press   <= press_d;
            rel     <= rel_d;
            lng     <= lng_d;
            rpt     <= rpt_d;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw button pads into debounced levels and press/release/long/repeat
// events; one independent channel per button.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int                 NUM_BTN         = 2,
    parameter logic [NUM_BTN-1:0] ACTIVE_HIGH     = '1,
    parameter int                 DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter int                 LONG_CYCLES     = DEF_LONG,
    parameter int                 REPEAT_CYCLES   = DEF_REPEAT
) (
    input logic                clk,
    input logic                reset_n,
    button_conditioner_if.slave bus
);

    localparam int CW =
        $clog2(max3(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES) + 1);

    if ((LONG_CYCLES <= DEBOUNCE_CYCLES) || (DEBOUNCE_CYCLES < 2)) begin : g_bad_cfg
        $error("button_conditioner: need LONG_CYCLES > DEBOUNCE_CYCLES >= 2");
    end

    logic [NUM_BTN-1:0] lvl, prs, rel, lng, rpt;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        button_channel #(
            .ACTIVE          (ACTIVE_HIGH[g]),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .CW              (CW)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (bus.btn_in[g]),
            .level   (lvl[g]),
            .press   (prs[g]),
            .rel     (rel[g]),
            .lng     (lng[g]),
            .rpt     (rpt[g])
        );
    end

    assign bus.btn_level   = lvl;
    assign bus.btn_press   = prs;
    assign bus.btn_release = rel;
    assign bus.btn_long    = lng;
    assign bus.btn_repeat  = rpt;

endmodule
